// File: rtl/dsc_sched_pkg.sv
// dsc_sched_pkg: shared types and constants for the dsc_mul scheduler.
//   state_t  - scheduler FSM states
//   *_DEF    - default parameter values of the scheduler
//   ID_W     - requester-id width for the default requester count
//   id_width - id width for any requester count (minimum 1 bit)
package dsc_sched_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLR    = 3'd1,
        RUN    = 3'd2,
        SETTLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam int NUM_REQ_DEF = 4;
    localparam int WIDTH_DEF   = 8;
    localparam int CYC_W_DEF   = 20;
    localparam int TIMEOUT_DEF = 65552;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ID_W = id_width(NUM_REQ_DEF);

endpackage

// File: rtl/dsc_mul_sched_if.sv
// dsc_mul_sched_if: requester-side bundle of the multiplier scheduler.
//   req/a_in/b_in                 - requests and packed operands (master drives)
//   gnt/done/done_id/z_out/
//   cyc_out/err                   - grant strobe and result (slave drives)
interface dsc_mul_sched_if #(
    parameter int NUM_REQ = dsc_sched_pkg::NUM_REQ_DEF,
    parameter int WIDTH   = dsc_sched_pkg::WIDTH_DEF,
    parameter int CYC_W   = dsc_sched_pkg::CYC_W_DEF
);
    localparam int IDW = dsc_sched_pkg::id_width(NUM_REQ);

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] a_in;
    logic [NUM_REQ*WIDTH-1:0] b_in;
    logic [NUM_REQ-1:0]       gnt;
    logic                     done;
    logic [IDW-1:0]           done_id;
    logic [2*WIDTH-1:0]       z_out;
    logic [CYC_W-1:0]         cyc_out;
    logic                     err;

    modport master (
        output req, a_in, b_in,
        input  gnt, done, done_id, z_out, cyc_out, err
    );

    modport slave (
        input  req, a_in, b_in,
        output gnt, done, done_id, z_out, cyc_out, err
    );
endinterface

// File: rtl/dsc_mul_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin search.
//   req      - request vector
//   ptr      - last winner; the search starts at ptr+1 and wraps
//   grant    - one-hot winner
//   grant_id - index of the winner
//   any      - at least one request present
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id,
    output logic           any
);
    // first set request after ptr, visiting ptr itself last
    always_comb begin
        int idx;
        grant    = '0;
        grant_id = '0;
        any      = 1'b0;
        idx      = 0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = IDW'(idx);
            end else begin
                any = any;
            end
        end
    end
endmodule

// File: rtl/dsc_mul_sched.sv
// dsc_mul_sched: round-robin sharing of one external dsc_mul among requesters.
//   clk, rst      - clock and asynchronous active-low reset
//   bus (slave)   - requests/operands in; grant, result, id, cycle count, timeout out
//   mul_rst/en    - control of the external multiplier (reset active-high)
//   mul_a/mul_b   - latched operands of the operation in flight
//   mul_z/mul_ov  - multiplier product and completion flag
// Zero operands skip the multiplier: the grant and result appear together.
module dsc_mul_sched
    import dsc_sched_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int WIDTH   = WIDTH_DEF,
    parameter int CYC_W   = CYC_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    dsc_mul_sched_if.slave     bus,
    output logic               mul_rst,
    output logic               mul_en,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    input  logic [2*WIDTH-1:0] mul_z,
    input  logic               mul_ov
);
    localparam int IDW = id_width(NUM_REQ);

    state_t               state_r;
    state_t               state_next_s;
    logic [IDW-1:0]       ptr_r;
    logic [IDW-1:0]       id_r;
    logic [WIDTH-1:0]     mul_a_r;
    logic [WIDTH-1:0]     mul_b_r;
    logic [CYC_W-1:0]     cnt_r;
    logic [NUM_REQ-1:0]   gnt_r;
    logic                 done_r;
    logic [IDW-1:0]       done_id_r;
    logic [2*WIDTH-1:0]   z_r;
    logic [CYC_W-1:0]     cyc_r;
    logic                 err_r;
    logic                 mul_rst_r;
    logic                 mul_en_r;

    logic [NUM_REQ-1:0]   arb_grant_s;
    logic [IDW-1:0]       arb_id_s;
    logic                 arb_any_s;
    logic [WIDTH-1:0]     win_a_s;
    logic [WIDTH-1:0]     win_b_s;
    logic                 bypass_s;
    logic                 timeout_s;

    rr_arbiter #(.N(NUM_REQ), .IDW(IDW)) u_arb (
        .req      (bus.req),
        .ptr      (ptr_r),
        .grant    (arb_grant_s),
        .grant_id (arb_id_s),
        .any      (arb_any_s)
    );

    // operand mux driven by the one-hot grant
    always_comb begin
        win_a_s = '0;
        win_b_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_a_s = win_a_s | (bus.a_in[i*WIDTH +: WIDTH] & {WIDTH{arb_grant_s[i]}});
            win_b_s = win_b_s | (bus.b_in[i*WIDTH +: WIDTH] & {WIDTH{arb_grant_s[i]}});
        end
    end

    assign bypass_s  = (win_a_s == '0) || (win_b_s == '0);
    assign timeout_s = (cnt_r == CYC_W'(TIMEOUT - 1));

    // next-state logic; ov beats a simultaneous timeout
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (arb_any_s) begin
                    state_next_s = bypass_s ? DONE : CLR;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CLR:    state_next_s = RUN;
            RUN: begin
                if (mul_ov) begin
                    state_next_s = SETTLE;
                end else if (timeout_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            SETTLE: state_next_s = DONE;
            DONE:   state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // multiplier controls registered from the next state so they line up with it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_rst_r <= 1'b1;
            mul_en_r  <= 1'b0;
        end else begin
            mul_rst_r <= (state_next_s == IDLE) || (state_next_s == CLR) || (state_next_s == DONE);
            mul_en_r  <= (state_next_s == RUN);
        end
    end

    // arbitration capture, run counter and result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_r     <= IDW'(NUM_REQ - 1);
            id_r      <= '0;
            mul_a_r   <= '0;
            mul_b_r   <= '0;
            cnt_r     <= '0;
            gnt_r     <= '0;
            done_r    <= 1'b0;
            done_id_r <= '0;
            z_r       <= '0;
            cyc_r     <= '0;
            err_r     <= 1'b0;
        end else begin
            gnt_r  <= '0;
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (arb_any_s) begin
                        mul_a_r <= win_a_s;
                        mul_b_r <= win_b_s;
                        id_r    <= arb_id_s;
                        ptr_r   <= arb_id_s;
                        gnt_r   <= arb_grant_s;
                        if (bypass_s) begin
                            done_r    <= 1'b1;
                            done_id_r <= arb_id_s;
                            z_r       <= '0;
                            cyc_r     <= '0;
                            err_r     <= 1'b0;
                        end
                    end
                end
                CLR: begin
                    cnt_r <= '0;
                end
                RUN: begin
                    cnt_r <= cnt_r + CYC_W'(1);
                    if (!mul_ov && timeout_s) begin
                        done_r    <= 1'b1;
                        done_id_r <= id_r;
                        z_r       <= '0;
                        cyc_r     <= CYC_W'(TIMEOUT);
                        err_r     <= 1'b1;
                    end
                end
                SETTLE: begin
                    done_r    <= 1'b1;
                    done_id_r <= id_r;
                    z_r       <= mul_z;
                    cyc_r     <= cnt_r;
                    err_r     <= 1'b0;
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign bus.gnt     = gnt_r;
    assign bus.done    = done_r;
    assign bus.done_id = done_id_r;
    assign bus.z_out   = z_r;
    assign bus.cyc_out = cyc_r;
    assign bus.err     = err_r;
    assign mul_rst     = mul_rst_r;
    assign mul_en      = mul_en_r;
    assign mul_a       = mul_a_r;
    assign mul_b       = mul_b_r;
endmodule

// File: tb/tb_dsc_mul_sched.sv
// tb_dsc_mul_sched: directed bench for dsc_mul_sched with a behavioural
// repeated-addition multiplier (ov after a*b enabled cycles).
module tb_dsc_mul_sched;
    logic        clk;
    logic        rst;
    logic        mul_rst, mul_en, mul_ov;
    logic [7:0]  mul_a, mul_b;
    logic [15:0] mul_z;
    logic [15:0] prod;
    logic [31:0] mcnt;
    logic        hang;
    int          tests, fails;

    dsc_mul_sched_if #(.NUM_REQ(4), .WIDTH(8), .CYC_W(20)) bus ();

    dsc_mul_sched #(.NUM_REQ(4), .WIDTH(8), .CYC_W(20), .TIMEOUT(65552)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .mul_rst (mul_rst),
        .mul_en  (mul_en),
        .mul_a   (mul_a),
        .mul_b   (mul_b),
        .mul_z   (mul_z),
        .mul_ov  (mul_ov)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // multiplier model: counts enabled cycles since its reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) mcnt <= 32'd0;
        else if (mul_rst) mcnt <= 32'd0;
        else if (mul_en) mcnt <= mcnt + 32'd1;
    end
    assign prod   = {8'd0, mul_a} * {8'd0, mul_b};
    assign mul_ov = !hang && mul_en && ((mcnt + 32'd1) >= {16'd0, prod});
    assign mul_z  = (!hang && (mcnt >= {16'd0, prod})) ? prod : 16'd0;

    typedef struct packed {
        logic [3:0]  req;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  gnt;
        logic [1:0]  id;
        logic [15:0] z;
        logic [31:0] lat;
        logic        byp;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    // one operation: raise rq, wait for grant, drop granted bit, wait for done
    task automatic run_one(input logic [3:0] rq, input bit keep, output logic [3:0] g,
                           output int lat, output bit saw_run, output int extra);
        bit got;
        got = 1'b0; g = 4'd0; lat = 0; saw_run = 1'b0; extra = 0;
        bus.req = rq;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (bus.gnt != 4'd0) got = 1'b1;
        end
        check("gnt_wait", {31'd0, got}, 32'd1);
        if (got) begin
            g = bus.gnt;
            bus.req = bus.req & ~g;
            lat = 1;
            while (!bus.done && lat < 70000) begin
                @(negedge clk);
                lat++;
                if (bus.gnt != 4'd0) extra++;
                if (mul_en || !mul_rst) saw_run = 1'b1;
            end
            check("done_wait", {31'd0, bus.done}, 32'd1);
        end
        if (!keep) bus.req = 4'd0;
    endtask

    initial begin
        logic [3:0]  g;
        int          lat, extra, sum;
        bit          sr;
        logic [15:0] cz[4];
        int          rid;
        logic [7:0]  ra, rb;

        tests = 0; fails = 0; hang = 1'b0; sum = 0;
        bus.req = 4'd0; bus.a_in = 32'd0; bus.b_in = 32'd0;

        vecs[0] = '{4'b0001, {8'd0,8'd0,8'd0,8'd15}, {8'd0,8'd0,8'd0,8'd15}, 4'b0001, 2'd0, 16'd225, 32'd228, 1'b0};
        vecs[1] = '{4'b0100, {8'd0,8'd3,8'd0,8'd0},  {8'd0,8'd7,8'd0,8'd0},  4'b0100, 2'd2, 16'd21,  32'd24,  1'b0};
        vecs[2] = '{4'b0010, {8'd0,8'd0,8'd0,8'd0},  {8'd0,8'd0,8'd200,8'd0},4'b0010, 2'd1, 16'd0,   32'd1,   1'b1};
        vecs[3] = '{4'b1000, {8'd200,8'd0,8'd0,8'd0},{8'd0,8'd0,8'd0,8'd0},  4'b1000, 2'd3, 16'd0,   32'd1,   1'b1};
        vecs[4] = '{4'b1010, {8'd9,8'd0,8'd5,8'd0},  {8'd9,8'd0,8'd4,8'd0},  4'b0010, 2'd1, 16'd20,  32'd23,  1'b0};
        vecs[5] = '{4'b1000, {8'd9,8'd0,8'd5,8'd0},  {8'd9,8'd0,8'd4,8'd0},  4'b1000, 2'd3, 16'd81,  32'd84,  1'b0};
        vecs[6] = '{4'b1111, {8'd1,8'd1,8'd1,8'd2},  {8'd1,8'd1,8'd1,8'd3},  4'b0001, 2'd0, 16'd6,   32'd9,   1'b0};
        vecs[7] = '{4'b0001, {8'd0,8'd0,8'd0,8'd255},{8'd0,8'd0,8'd0,8'd1},  4'b0001, 2'd0, 16'd255, 32'd258, 1'b0};

        // reset values
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_gnt", {28'd0, bus.gnt}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_mul_rst", {31'd0, mul_rst}, 32'd1);
        check("rst_mul_en", {31'd0, mul_en}, 32'd0);
        check("rst_z", {16'd0, bus.z_out}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // contention: all four request together, distinct operands
        cz[0] = 16'd30; cz[1] = 16'd8; cz[2] = 16'd9; cz[3] = 16'd20;
        bus.a_in = {8'd4, 8'd3, 8'd2, 8'd5};
        bus.b_in = {8'd5, 8'd3, 8'd4, 8'd6};
        bus.req  = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            run_one(bus.req, 1'b1, g, lat, sr, extra);
            check("cont_gnt", {28'd0, g}, {28'd0, 4'(4'b0001 << i)});
            check("cont_id", {30'd0, bus.done_id}, 32'(i));
            check("cont_z", {16'd0, bus.z_out}, {16'd0, cz[i]});
            check("cont_single_gnt", 32'(extra), 32'd0);
        end
        run_one(4'b0001, 1'b0, g, lat, sr, extra);
        check("cont_regrant", {28'd0, g}, 32'd1);
        check("cont_regrant_z", {16'd0, bus.z_out}, 32'd30);

        // table-driven single operations
        for (int i = 0; i < 8; i++) begin
            bus.a_in = vecs[i].a;
            bus.b_in = vecs[i].b;
            run_one(vecs[i].req, 1'b0, g, lat, sr, extra);
            check("vec_gnt", {28'd0, g}, {28'd0, vecs[i].gnt});
            check("vec_id", {30'd0, bus.done_id}, {30'd0, vecs[i].id});
            check("vec_z", {16'd0, bus.z_out}, {16'd0, vecs[i].z});
            check("vec_cyc", {12'd0, bus.cyc_out}, {16'd0, vecs[i].z});
            check("vec_err", {31'd0, bus.err}, 32'd0);
            check("vec_lat", 32'(lat), vecs[i].lat);
            check("vec_bypass", {31'd0, sr}, {31'd0, !vecs[i].byp});
        end

        // timeout: multiplier never finishes
        hang = 1'b1;
        bus.a_in = {24'd0, 8'd1};
        bus.b_in = {24'd0, 8'd1};
        run_one(4'b0001, 1'b0, g, lat, sr, extra);
        check("to_err", {31'd0, bus.err}, 32'd1);
        check("to_z", {16'd0, bus.z_out}, 32'd0);
        check("to_cyc", {12'd0, bus.cyc_out}, 32'd65552);
        check("to_lat", 32'(lat), 32'd65554);
        hang = 1'b0;
        bus.a_in = {24'd0, 8'd2};
        bus.b_in = {24'd0, 8'd2};
        run_one(4'b0001, 1'b0, g, lat, sr, extra);
        check("to_clear_err", {31'd0, bus.err}, 32'd0);
        check("to_next_z", {16'd0, bus.z_out}, 32'd4);

        // reset during RUN cycle 100 of requester 2
        bus.a_in = {8'd0, 8'd15, 8'd0, 8'd0};
        bus.b_in = {8'd0, 8'd15, 8'd0, 8'd0};
        run_one(4'b0100, 1'b0, g, lat, sr, extra);
        bus.req = 4'b0100;
        lat = 0;
        while (bus.gnt == 4'd0 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("mr_gnt", {28'd0, bus.gnt}, 32'd4);
        bus.req = 4'd0;
        repeat (100) @(negedge clk);
        check("mr_in_run", {31'd0, mul_en}, 32'd1);
        rst = 1'b0;
        #1;
        check("mr_z", {16'd0, bus.z_out}, 32'd0);
        check("mr_cyc", {12'd0, bus.cyc_out}, 32'd0);
        check("mr_mul_rst", {31'd0, mul_rst}, 32'd1);
        check("mr_mul_en", {31'd0, mul_en}, 32'd0);
        check("mr_mul_a", {24'd0, mul_a}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        extra = 0;
        repeat (300) begin
            @(negedge clk);
            if (bus.done) extra++;
        end
        check("mr_no_done", 32'(extra), 32'd0);
        bus.a_in = {8'd1, 8'd1, 8'd1, 8'd3};
        bus.b_in = {8'd1, 8'd1, 8'd1, 8'd1};
        run_one(4'b1111, 1'b0, g, lat, sr, extra);
        check("mr_prio0", {28'd0, g}, 32'd1);
        check("mr_prio0_z", {16'd0, bus.z_out}, 32'd3);

        // short random regression with small operands
        for (int i = 0; i < 20; i++) begin
            rid = int'($urandom_range(0, 3));
            ra  = 8'($urandom_range(0, 15));
            rb  = 8'($urandom_range(0, 15));
            bus.a_in = 32'd0;
            bus.b_in = 32'd0;
            bus.a_in[rid*8 +: 8] = ra;
            bus.b_in[rid*8 +: 8] = rb;
            run_one(4'(4'b0001 << rid), 1'b0, g, lat, sr, extra);
            check("rnd_id", {30'd0, bus.done_id}, 32'(rid));
            check("rnd_z", {16'd0, bus.z_out}, 32'(ra) * 32'(rb));
            check("rnd_cyc", {12'd0, bus.cyc_out}, 32'(ra) * 32'(rb));
            sum += int'(bus.cyc_out);
        end
        $display("[TB] random average cyc_out %0d", sum / 20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dsc_mul_sched.md
Name: dsc_mul_sched

Overview:
Round-robin scheduler that shares one dsc_mul instance among NUM_REQ requesters.
- Arbitrates requests and latches the winning operands.
- Pulses the multiplier's reset, enables it until its ov flag, then captures the product.
- Returns the product, requester id, elapsed run cycles and a timeout flag.
- Zero operands bypass the multiplier entirely.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
WIDTH, 8, operand width; product is 2*WIDTH
CYC_W, 20, cycle-counter width; must exceed clog2(TIMEOUT)
TIMEOUT, 65552, maximum RUN cycles before abort (2^(2*WIDTH)+16)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous reset, active-low
req  in  NUM_REQ  per-requester request; held with operands until gnt seen
a_in  in  NUM_REQ*WIDTH  operand a, requester i at [i*WIDTH +: WIDTH]
b_in  in  NUM_REQ*WIDTH  operand b, same packing
gnt  out  NUM_REQ  one-hot, one-cycle grant (operands already latched)
done  out  1  one-cycle result strobe
done_id  out  clog2(NUM_REQ)  requester owning the result
z_out  out  2*WIDTH  product
cyc_out  out  CYC_W  RUN cycles consumed (0 for bypass)
err  out  1  timeout flag, valid with done
mul_rst  out  1  to dsc_mul rst (active-high)
mul_en  out  1  to dsc_mul en
mul_a, mul_b  out  WIDTH  latched operands to dsc_mul
mul_z  in  2*WIDTH  dsc_mul z
mul_ov  in  1  dsc_mul ov (operation finished)

Behaviour:
- Reset (rst low, async) values:
  - state IDLE, mul_rst=1 (multiplier held in reset), mul_en=0.
  - gnt=0, done=0, err=0.
  - z_out, cyc_out, done_id, mul_a, mul_b all 0.
  - RR pointer=NUM_REQ-1, so requester 0 has first priority.
- IDLE:
  - mul_rst=1, mul_en=0.
  - If any req: winner = first set bit searching from pointer+1 with wrap.
  - At that edge: latch operands into mul_a/mul_b, latch id, pointer=winner.
  - If either operand is 0 go to DONE (bypass); else go to CLR.
- CLR: 1 cycle; mul_rst=1, mul_en=0; gnt[id]=1; cycle counter cleared.
- RUN:
  - mul_rst=0, mul_en=1; counter increments each cycle.
  - mul_ov sampled 1 -> SETTLE.
  - Else if counter==TIMEOUT-1 -> DONE with err.
  - mul_ov and timeout in the same cycle: mul_ov wins, err=0.
- SETTLE: 1 cycle; mul_en=0, mul_rst=0; at its end z_out<=mul_z, cyc_out<=counter.
- DONE:
  - done=1 for 1 cycle, done_id valid.
  - err=1 only on timeout; on timeout z_out=0 and cyc_out=TIMEOUT.
  - On bypass: gnt[id]=1 in this cycle, z_out=0, cyc_out=0.
  - Next state IDLE.
- Outputs z_out/cyc_out/done_id/err are registered and hold until the next DONE; err clears on the next DONE.
- Handshake:
  - Requester drops req at the edge where it samples gnt.
  - req is ignored outside IDLE.
  - No backpressure on done.
- Latency, grant edge to done:
  - Normal: 1 (CLR) + N (RUN cycles, including the one where mul_ov is sampled) + 1 (SETTLE) + 1 (DONE).
  - Bypass: done in the cycle after the grant edge.
- Reset mid-operation returns immediately to reset values; the in-flight request is lost and no done is issued.
- req bit falling before gnt: that requester is simply not selected; no error.

Decomposition:
- Package dsc_sched_pkg holds:
  - state enum {IDLE, CLR, RUN, SETTLE, DONE}.
  - Localparam ID_W=clog2(NUM_REQ).
- One sub-module, rr_arbiter: combinational priority search from pointer+1.
  - Ports: req, ptr -> grant one-hot, grant_id, any.
- FSM, counter and datapath registers live in the top.
- dsc_mul is instantiated by the parent, not inside this block.

Test Plan:
- Single request: req=0001, a=15, b=15; mul model asserts ov after 225 RUN cycles with z=225.
  -> gnt=0001 one cycle; done_id=0, z_out=225, cyc_out=225, err=0; done exactly 228 cycles after the grant edge.
- Contention: req=1111 held from reset with distinct operands.
  -> grant order 0,1,2,3, then 0 again on re-request.
  -> each done_id and z_out matches its requester; no two grants within one operation.
- Bypass: a=0, b=200.
  -> no CLR/RUN (mul_rst stays 1, mul_en never 1); gnt and done in the same cycle one cycle after the grant edge; z_out=0, cyc_out=0.
- Timeout: model never asserts ov.
  -> done after TIMEOUT RUN cycles with err=1, z_out=0, cyc_out=65552; the next normal operation clears err.
- Reset mid-RUN: rst low 3 cycles at RUN cycle 100.
  -> all outputs at reset values asynchronously; mul_rst=1; no done issued; next request is served from requester 0 priority.
- Random regression: 1000 random a/b pairs through a real dsc_mul.
  -> z_out == a*b for every done; average cyc_out reported.
